axi_lut_multiplier: RTL

Parametrised times-table lookup engine: accepts an operand pair on a valid/ready request port, issues one AXI4-Lite read to a product table held in block memory, and returns the product on a valid/ready response port. Replaces the fixed 3-bit, free-running lookup wrapper with a fully handshaked AXI4-Lite read master, generalised operand widths, a base address, error reporting and a completed-lookup counter. Sits between user logic and the AXI4-Lite BRAM controller holding the table.

---
 rtl/lut_mul_pkg.sv | 23 ++
 rtl/axi_lut_multiplier.sv | 121 ++++++++++++
 2 files changed

// File: rtl/lut_mul_pkg.sv
// Shared types for the AXI4-Lite times-table lookup engine.
// FSM encodings, AXI response codes and the table index helper.
package lut_mul_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_AR   = 2'd1;
  localparam logic [1:0] S_R    = 2'd2;
  localparam logic [1:0] S_RSP  = 2'd3;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  // Row-major index: a selects the row of 2^b_w entries.
  function automatic logic [31:0] lut_index(
    input logic [31:0] a,
    input logic [31:0] b,
    input int unsigned b_w
  );
    return (a << b_w) | b;
  endfunction

endpackage

// File: rtl/axi_lut_multiplier.sv
// Times-table lookup: one AXI4-Lite read per operand pair.
// Define LUT_MUL_CHECK_EN to cross-check table data against a*b.
module axi_lut_multiplier
  import lut_mul_pkg::*;
#(
  parameter int          A_W       = 3,
  parameter int          B_W       = 3,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int          ADDR_W    = 32,
  parameter int          DATA_W    = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [A_W-1:0]     req_a,
  input  logic [B_W-1:0]     req_b,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [A_W+B_W-1:0] rsp_result,
  output logic               rsp_err,
  output logic [15:0]        lookup_count,
  output logic [ADDR_W-1:0]  m_axi_araddr,
  output logic               m_axi_arvalid,
  input  logic               m_axi_arready,
  input  logic [DATA_W-1:0]  m_axi_rdata,
  input  logic [1:0]         m_axi_rresp,
  input  logic               m_axi_rvalid,
  output logic               m_axi_rready
);

  localparam int P_W = A_W + B_W;

  logic [1:0]        state;
  logic [ADDR_W-1:0] addr_next;
  logic              rd_err;

  assign addr_next = ADDR_W'(BASE_ADDR)
    + ADDR_W'({lut_index(32'(req_a), 32'(req_b), B_W), 2'b00});

`ifdef LUT_MUL_CHECK_EN
  logic [A_W-1:0] a_q;
  logic [B_W-1:0] b_q;
  logic [P_W-1:0] prod;

  assign prod   = P_W'(a_q) * P_W'(b_q);
  assign rd_err = (m_axi_rresp != AXI_RESP_OKAY)
    || (m_axi_rdata[P_W-1:0] != prod);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
    end else if (state == S_IDLE && req_valid && req_ready) begin
      a_q <= req_a;
      b_q <= req_b;
    end
  end
`else
  assign rd_err = (m_axi_rresp != AXI_RESP_OKAY);
`endif

  generate
    if (DATA_W > P_W) begin : g_pad
      logic unused_rdata;
      assign unused_rdata = ^m_axi_rdata[DATA_W-1:P_W];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      req_ready     <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_result    <= '0;
      rsp_err       <= 1'b0;
      lookup_count  <= '0;
      m_axi_araddr  <= '0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            m_axi_araddr  <= addr_next;
            m_axi_arvalid <= 1'b1;
            req_ready     <= 1'b0;
            state         <= S_AR;
          end else begin
            req_ready <= 1'b1;
          end
        end
        S_AR: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            state         <= S_R;
          end
        end
        S_R: begin
          if (m_axi_rvalid) begin
            m_axi_rready <= 1'b0;
            rsp_result   <= m_axi_rdata[P_W-1:0];
            rsp_err      <= rd_err;
            rsp_valid    <= 1'b1;
            state        <= S_RSP;
          end
        end
        S_RSP: begin
          if (rsp_ready) begin
            rsp_valid    <= 1'b0;
            lookup_count <= lookup_count + 16'd1;
            req_ready    <= 1'b1;
            state        <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule
